// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit add/subtract unit (ADD/SUB/ADC/SBC) with
// valid/ready handshakes on both sides and a registered NZCV flag set.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b, op, sat)
//   op                    00 ADD, 01 SUB, 10 ADC, 11 SBC
//   sat                   signed-saturate request (ADDSUB_SAT_EN builds only)
//   out_valid/out_ready   result handshake
//   result                sum/difference of the beat at the head of the pipe
//   flag_n/z/c/v          flags of the last delivered beat
//
// Build option: define ADDSUB_SAT_EN to enable signed saturation when sat=1.
//
// Arithmetic happens in slot 0; later slots only register. Each slot carries
// its own valid bit, so bubbles collapse under backpressure.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_z
);

  logic [STAGES-1:0]            vld_pipe, c_pipe, v_pipe, rdy;
  logic [STAGES-1:0][WIDTH-1:0] res_pipe;

  logic             cin, cout, c_msb, s_c, s_v, accept;
  logic [WIDTH-1:0] bx, s_res;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] low;

  // First-stage arithmetic. Subtraction is a + ~b + cin.
  always_comb begin
    bx = op[0] ? ~b : b;
    unique case (op)
      2'b00:   cin = 1'b0;
      2'b01:   cin = 1'b1;
      2'b10:   cin = flag_c;
      default: cin = ~flag_c;
    endcase
    sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    // Carry into the MSB, for signed overflow.
    low   = {1'b0, a[WIDTH-2:0]} + {1'b0, bx[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};
    cout  = sum[WIDTH];
    c_msb = low[WIDTH-1];
    s_v   = c_msb ^ cout;
    s_c   = op[0] ? ~cout : cout;   // borrow for SUB/SBC
    s_res = sum[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
    // Overflow with a set MSB means the true result was positive.
    if (sat && s_v)
      s_res = sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
  end

`ifndef ADDSUB_SAT_EN
  logic sat_unused;
  assign sat_unused = sat;
`endif

  // Slot k can take new contents when it, or any slot downstream of it, is
  // empty, or when the tail is draining this cycle.
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign rdy[k] = out_ready | ~(&vld_pipe[STAGES-1:k]);
  end

  // ADC/SBC consume flag_c, which only settles once every older beat has
  // been delivered, so they wait for an empty pipe.
  assign in_ready  = !rst && rdy[0] && !(in_valid && op[1] && (|vld_pipe));
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[STAGES-1];
  assign result    = res_pipe[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      c_pipe   <= '0;
      v_pipe   <= '0;
      res_pipe <= '0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      if (rdy[0]) begin
        vld_pipe[0] <= accept;
        if (accept) begin
          res_pipe[0] <= s_res;
          c_pipe[0]   <= s_c;
          v_pipe[0]   <= s_v;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          res_pipe[k] <= res_pipe[k-1];
          c_pipe[k]   <= c_pipe[k-1];
          v_pipe[k]   <= v_pipe[k-1];
        end
      end
      // Flags follow the beat actually handed downstream.
      if (vld_pipe[STAGES-1] && out_ready) begin
        flag_c <= c_pipe[STAGES-1];
        flag_v <= v_pipe[STAGES-1];
        flag_n <= res_pipe[STAGES-1][WIDTH-1];
        flag_z <= ~|res_pipe[STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed testbench for addsub_pipe (WIDTH=32, STAGES=2). A negedge monitor
// checks each delivered beat against a queue of hand-computed expectations
// and checks the flags one cycle later. Flags are packed as {N,Z,C,V}.
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sat, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [1:0]  op;
  logic        flag_c, flag_v, flag_n, flag_z;
  logic [3:0]  flags;

  assign flags = {flag_n, flag_z, flag_c, flag_v};

  addsub_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sat(sat), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_c(flag_c),
    .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] r; logic [3:0] f; } exp_t;
  exp_t q[$];

  int nchk = 0, nerr = 0, ndone = 0, nexp = 0;
  logic       pend = 1'b0;
  logic [3:0] pend_f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk("flags", {28'd0, flags}, {28'd0, pend_f});
      pend = 1'b0;
    end
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("stale_valid", {31'd0, out_valid}, 32'd0);
      else begin
        e = q.pop_front();
        chk("result", result, e.r);
        pend_f = e.f;
        pend   = 1'b1;
        ndone++;
      end
    end
  end

  task automatic push(input logic [31:0] r, input logic [3:0] f);
    exp_t e;
    e.r = r; e.f = f;
    q.push_back(e);
    nexp++;
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic s);
    int n = 0;
    in_valid = 1'b1; op = o; a = x; b = y; sat = s;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 50) begin
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("drain", q.size(), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b1; a = 32'd7; b = 32'd7; op = 2'b00; sat = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_result",    result,             32'd0);
    chk("reset_flags",     {28'd0, flags},     32'd0);
    @(posedge clk); #1;

    // Signed overflow and two-cycle latency.
    push(32'h8000_0000, 4'b1001);
    send(2'b00, 32'h7FFF_FFFF, 32'h1, 1'b0);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (out_valid) break;
    end
    chk("latency", lat, 32'd2);
    drain();

    // Subtraction: zero and borrow.
    push(32'h0, 4'b0100);
    send(2'b01, 32'd5, 32'd5, 1'b0);
    push(32'hFFFF_FFFE, 4'b1010);
    send(2'b01, 32'd3, 32'd5, 1'b0);
    drain();

    // ADC behind an in-flight ADD: interlock until the pipe empties.
    push(32'h0, 4'b0110);
    push(32'h1, 4'b0000);
    send(2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0);
    in_valid = 1'b1; op = 2'b10; a = 32'h0; b = 32'h0;
    @(negedge clk); chk("hazard_rdy0", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("hazard_rdy1", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("hazard_rdy2", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Backpressure: two slots fill, third beat waits, order preserved.
    out_ready = 1'b0;
    push(32'd2, 4'b0000); push(32'd4, 4'b0000); push(32'd6, 4'b0000);
    send(2'b00, 32'd1, 32'd1, 1'b0);
    send(2'b00, 32'd2, 32'd2, 1'b0);
    in_valid = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", result, 32'd2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(2'b00, 32'd3, 32'd3, 1'b0);
    drain();

    // Saturation requests at both signed extremes.
`ifdef ADDSUB_SAT_EN
    push(32'h7FFF_FFFF, 4'b0001);
    push(32'h8000_0000, 4'b1011);
`else
    push(32'h8000_0000, 4'b1001);
    push(32'h7FFF_FFFF, 4'b0011);
`endif
    send(2'b00, 32'h7FFF_FFFF, 32'h1, 1'b1);
    send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain();

    // Reset with two beats in flight: nothing stale afterwards.
    push(32'hFFFF_FFFE, 4'b1010);
    send(2'b01, 32'd3, 32'd5, 1'b0);
    drain();
    out_ready = 1'b0;
    send(2'b00, 32'd1, 32'd1, 1'b0);
    send(2'b00, 32'd2, 32'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_result",    result,             32'd0);
    chk("flush_flags",     {28'd0, flags},     32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("beat_count", ndone, nexp);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
